// File: rtl/axis_constant_sequencer.sv
// +----------------------------------------------------------------------------+
// | axis_constant_sequencer                                                    |
// | Emits a snapshot of a programmable constant table on AXI-stream per sync.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module axis_constant_sequencer #(
  parameter int N_CONSTANTS = 4,
  parameter int DATA_WIDTH  = 64,
  parameter int DEST_WIDTH  = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  sync,
  output logic [DATA_WIDTH-1:0] const_out_data,
  output logic [DEST_WIDTH-1:0] const_out_dest,
  output logic                  const_out_valid,
  output logic                  const_out_last,
  input  logic                  const_out_ready,
  input  logic [31:0]           axil_awaddr,
  input  logic                  axil_awvalid,
  output logic                  axil_awready,
  input  logic [31:0]           axil_wdata,
  input  logic [3:0]            axil_wstrb,
  input  logic                  axil_wvalid,
  output logic                  axil_wready,
  output logic [1:0]            axil_bresp,
  output logic                  axil_bvalid,
  input  logic                  axil_bready,
  input  logic [31:0]           axil_araddr,
  input  logic                  axil_arvalid,
  output logic                  axil_arready,
  output logic [31:0]           axil_rdata,
  output logic [1:0]            axil_rresp,
  output logic                  axil_rvalid,
  input  logic                  axil_rready
);

  localparam int          c_IDX_W       = (N_CONSTANTS > 1) ? $clog2(N_CONSTANTS) : 1;
  localparam int          c_HI_W        = DATA_WIDTH - 32;
  localparam logic [3:0]  c_N_MAX       = 4'(N_CONSTANTS);
  localparam logic [31:0] c_ADDR_CTRL   = 32'h0000_0000;
  localparam logic [31:0] c_ADDR_STATUS = 32'h0000_0004;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  function automatic logic [31:0] f_merge(input logic [31:0] old_v,
                                          input logic [31:0] new_v,
                                          input logic [3:0]  strb);
    logic [31:0] v;
    v = old_v;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) v[8*b +: 8] = new_v[8*b +: 8];
    end
    return v;
  endfunction

  state_t                r_state;
  logic                  r_enable;
  logic                  r_one_shot;
  logic [3:0]            r_n_active;
  logic [15:0]           r_overrun;
  logic                  r_bvalid;
  logic                  r_rvalid;
  logic [31:0]           r_rdata;
  logic [c_IDX_W-1:0]    r_idx;
  logic [3:0]            r_n_shadow;
  logic                  r_valid;
  logic                  r_last;
  logic [DATA_WIDTH-1:0] r_data;
  logic [DEST_WIDTH-1:0] r_dest;
  logic [DATA_WIDTH-1:0] r_shadow_data [N_CONSTANTS];
  logic [DEST_WIDTH-1:0] r_shadow_dest [N_CONSTANTS];

  logic [31:0]           w_slot_low    [N_CONSTANTS];
  logic [31:0]           w_slot_high   [N_CONSTANTS];
  logic [DEST_WIDTH-1:0] w_slot_dest   [N_CONSTANTS];
  logic [DATA_WIDTH-1:0] w_slot_data   [N_CONSTANTS];

  logic                  w_wr_fire;
  logic                  w_wr_ctrl;
  logic                  w_wr_status;
  logic [31:0]           w_ctrl_word;
  logic [31:0]           w_ctrl_merged;
  logic                  w_start;
  logic                  w_rd_fire;
  logic [31:0]           w_rd_data;
  logic [3:0]            w_n_eff;
  logic                  w_trigger;
  logic                  w_busy;
  logic                  w_final_hs;
  logic [c_IDX_W-1:0]    w_idx_next;
  logic                  w_last_next;
  logic [DATA_WIDTH-1:0] w_next_data;
  logic [DEST_WIDTH-1:0] w_next_dest;
  logic                  w_unused_ctrl;

  // ---------------- AXI-lite write channel ----------------
  // Address and data are accepted together; one write outstanding at a time.
  assign w_wr_fire     = axil_awvalid & axil_wvalid & ~r_bvalid;
  assign axil_awready  = w_wr_fire;
  assign axil_wready   = w_wr_fire;
  assign axil_bvalid   = r_bvalid;
  assign axil_bresp    = 2'b00;

  assign w_wr_ctrl     = w_wr_fire & (axil_awaddr == c_ADDR_CTRL);
  assign w_wr_status   = w_wr_fire & (axil_awaddr == c_ADDR_STATUS);
  assign w_ctrl_word   = {20'd0, r_n_active, 5'd0, 1'b0, r_one_shot, r_enable};
  assign w_ctrl_merged = f_merge(w_ctrl_word, axil_wdata, axil_wstrb);
  assign w_start       = w_wr_ctrl & axil_wstrb[0] & axil_wdata[2];
  assign w_unused_ctrl = &{1'b0, w_ctrl_merged};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_bvalid <= 1'b0;
    end else if (w_wr_fire) begin
      r_bvalid <= 1'b1;
    end else if (axil_bready) begin
      r_bvalid <= 1'b0;
    end
  end

  // ---------------- Slot table ----------------
  for (genvar gi = 0; gi < N_CONSTANTS; gi++) begin : g_slot
    localparam logic [31:0] c_BASE = 32'(16 + 16 * gi);
    logic [31:0]           r_low;
    logic [31:0]           r_high;
    logic [DEST_WIDTH-1:0] r_dst;
    logic [31:0]           w_dest_merged;
    logic                  w_unused_slot;

    assign w_dest_merged = f_merge(32'(r_dst), axil_wdata, axil_wstrb);
    assign w_unused_slot = &{1'b0, r_high, w_dest_merged};

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        r_low  <= '0;
        r_high <= '0;
        r_dst  <= '0;
      end else if (w_wr_fire) begin
        if (axil_awaddr == c_BASE)         r_low  <= f_merge(r_low, axil_wdata, axil_wstrb);
        if (axil_awaddr == c_BASE + 32'h4) r_high <= f_merge(r_high, axil_wdata, axil_wstrb);
        if (axil_awaddr == c_BASE + 32'h8) r_dst  <= w_dest_merged[DEST_WIDTH-1:0];
      end
    end

    assign w_slot_low[gi]  = r_low;
    assign w_slot_high[gi] = r_high;
    assign w_slot_dest[gi] = r_dst;
    assign w_slot_data[gi] = {r_high[c_HI_W-1:0], r_low};
  end

  // ---------------- Control and status ----------------
  assign w_n_eff    = (r_n_active > c_N_MAX) ? c_N_MAX : r_n_active;
  assign w_trigger  = (sync & r_enable) | w_start;
  assign w_busy     = (r_state == ST_RUN);
  assign w_final_hs = w_busy & r_valid & const_out_ready & r_last;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_enable   <= 1'b0;
      r_one_shot <= 1'b0;
      r_n_active <= 4'd0;
    end else begin
      if (w_wr_ctrl) begin
        r_enable   <= w_ctrl_merged[0];
        r_one_shot <= w_ctrl_merged[1];
        r_n_active <= w_ctrl_merged[11:8];
      end
      // One-shot disarm takes priority over a coincident CTRL write.
      if (w_final_hs && r_one_shot) r_enable <= 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_overrun <= 16'd0;
    end else if (w_wr_status) begin
      r_overrun <= 16'd0;
    end else if (w_trigger && w_busy && (r_overrun != 16'hFFFF)) begin
      r_overrun <= r_overrun + 16'd1;
    end
  end

  // ---------------- AXI-lite read channel ----------------
  assign w_rd_fire    = axil_arvalid & ~r_rvalid;
  assign axil_arready = ~r_rvalid;
  assign axil_rvalid  = r_rvalid;
  assign axil_rdata   = r_rdata;
  assign axil_rresp   = 2'b00;

  always_comb begin
    w_rd_data = 32'd0;
    if (axil_araddr == c_ADDR_CTRL)   w_rd_data = w_ctrl_word;
    if (axil_araddr == c_ADDR_STATUS) w_rd_data = {r_overrun, 15'd0, w_busy};
    for (int i = 0; i < N_CONSTANTS; i++) begin
      if (axil_araddr == 32'(16 + 16 * i))     w_rd_data = w_slot_low[i];
      if (axil_araddr == 32'(16 + 16 * i + 4)) w_rd_data = w_slot_high[i];
      if (axil_araddr == 32'(16 + 16 * i + 8)) w_rd_data = 32'(w_slot_dest[i]);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rvalid <= 1'b0;
      r_rdata  <= 32'd0;
    end else if (w_rd_fire) begin
      r_rvalid <= 1'b1;
      r_rdata  <= w_rd_data;
    end else if (axil_rready) begin
      r_rvalid <= 1'b0;
    end
  end

  // ---------------- Sequencer ----------------
  assign w_idx_next  = r_idx + c_IDX_W'(1);
  assign w_last_next = (4'(w_idx_next) == (r_n_shadow - 4'd1));

  always_comb begin
    w_next_data = '0;
    w_next_dest = '0;
    for (int i = 0; i < N_CONSTANTS; i++) begin
      if (c_IDX_W'(i) == w_idx_next) begin
        w_next_data = r_shadow_data[i];
        w_next_dest = r_shadow_dest[i];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_idx      <= '0;
      r_n_shadow <= 4'd0;
      r_valid    <= 1'b0;
      r_last     <= 1'b0;
      r_data     <= '0;
      r_dest     <= '0;
      for (int i = 0; i < N_CONSTANTS; i++) begin
        r_shadow_data[i] <= '0;
        r_shadow_dest[i] <= '0;
      end
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_trigger && (w_n_eff != 4'd0)) begin
            for (int i = 0; i < N_CONSTANTS; i++) begin
              r_shadow_data[i] <= w_slot_data[i];
              r_shadow_dest[i] <= w_slot_dest[i];
            end
            r_n_shadow <= w_n_eff;
            r_idx      <= '0;
            r_valid    <= 1'b1;
            r_data     <= w_slot_data[0];
            r_dest     <= w_slot_dest[0];
            r_last     <= (w_n_eff == 4'd1);
            r_state    <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (r_valid && const_out_ready) begin
            if (r_last) begin
              r_valid <= 1'b0;
              r_last  <= 1'b0;
              r_idx   <= '0;
              r_state <= ST_IDLE;
            end else begin
              r_idx  <= w_idx_next;
              r_data <= w_next_data;
              r_dest <= w_next_dest;
              r_last <= w_last_next;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign const_out_valid = r_valid;
  assign const_out_last  = r_last;
  assign const_out_data  = r_data;
  assign const_out_dest  = r_dest;

endmodule

`default_nettype wire

// File: tb/tb_axis_constant_sequencer.sv
// +----------------------------------------------------------------------------+
// | tb_axis_constant_sequencer                                                 |
// | Scoreboard bench: expected beats are queued, a monitor pops on handshake.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_axis_constant_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        sync;
  logic [63:0] const_out_data;
  logic [7:0]  const_out_dest;
  logic        const_out_valid;
  logic        const_out_last;
  logic        const_out_ready;
  logic [31:0] axil_awaddr;
  logic        axil_awvalid;
  logic        axil_awready;
  logic [31:0] axil_wdata;
  logic [3:0]  axil_wstrb;
  logic        axil_wvalid;
  logic        axil_wready;
  logic [1:0]  axil_bresp;
  logic        axil_bvalid;
  logic        axil_bready;
  logic [31:0] axil_araddr;
  logic        axil_arvalid;
  logic        axil_arready;
  logic [31:0] axil_rdata;
  logic [1:0]  axil_rresp;
  logic        axil_rvalid;
  logic        axil_rready;

  axis_constant_sequencer #(
    .N_CONSTANTS(4),
    .DATA_WIDTH (64),
    .DEST_WIDTH (8)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .sync           (sync),
    .const_out_data (const_out_data),
    .const_out_dest (const_out_dest),
    .const_out_valid(const_out_valid),
    .const_out_last (const_out_last),
    .const_out_ready(const_out_ready),
    .axil_awaddr    (axil_awaddr),
    .axil_awvalid   (axil_awvalid),
    .axil_awready   (axil_awready),
    .axil_wdata     (axil_wdata),
    .axil_wstrb     (axil_wstrb),
    .axil_wvalid    (axil_wvalid),
    .axil_wready    (axil_wready),
    .axil_bresp     (axil_bresp),
    .axil_bvalid    (axil_bvalid),
    .axil_bready    (axil_bready),
    .axil_araddr    (axil_araddr),
    .axil_arvalid   (axil_arvalid),
    .axil_arready   (axil_arready),
    .axil_rdata     (axil_rdata),
    .axil_rresp     (axil_rresp),
    .axil_rvalid    (axil_rvalid),
    .axil_rready    (axil_rready)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  dest;
    logic        last;
  } beat_t;

  localparam logic [63:0] D0  = 64'h0000_0011_1000_0001;
  localparam logic [63:0] D1  = 64'h0000_0022_2000_0002;
  localparam logic [63:0] D2  = 64'h0000_0033_3000_0003;
  localparam logic [63:0] D3  = 64'h0000_0044_4000_0004;
  localparam logic [63:0] D1N = 64'h0000_0022_0000_DEAD;

  beat_t       sb[$];
  int          tests = 0;
  int          fails = 0;
  int          valid_cycles = 0;
  logic        stall_pending = 1'b0;
  logic [73:0] held;
  logic [31:0] rd;

  task automatic check(input string name, input logic [79:0] got, input logic [79:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic timeout(input string name);
    tests++;
    fails++;
    $display("FAIL %s: timed out, got no response expected a handshake", name);
  endtask

  task automatic push(input logic [63:0] d, input logic [7:0] t, input logic l);
    sb.push_back(beat_t'{data: d, dest: t, last: l});
  endtask

  task automatic push3(input logic [63:0] mid);
    push(D0, 8'd1, 1'b0);
    push(mid, 8'd2, 1'b0);
    push(D2, 8'd3, 1'b1);
  endtask

  // Monitor: pops the scoreboard on every handshake and checks stall stability.
  always @(negedge clock) begin
    beat_t e;
    if (reset) begin
      stall_pending = 1'b0;
    end else begin
      if (const_out_valid) valid_cycles++;
      if (stall_pending)
        check("stall_hold", 80'({const_out_valid, const_out_last, const_out_dest, const_out_data}),
              80'(held));
      if (const_out_valid && const_out_ready) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_beat: got data 0x%0h dest %0d, expected no beat",
                   const_out_data, const_out_dest);
        end else begin
          e = sb.pop_front();
          check("beat", 80'({const_out_last, const_out_dest, const_out_data}),
                80'({e.last, e.dest, e.data}));
        end
      end
      stall_pending = const_out_valid & ~const_out_ready;
      held = {1'b1, const_out_last, const_out_dest, const_out_data};
    end
  end

  // All tasks below are entered and left 1 ns after a rising edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic sync_pulse;
    sync = 1'b1;
    step(1);
    sync = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bit ok = 0;
    axil_awaddr = a; axil_wdata = d; axil_wstrb = 4'hF;
    axil_awvalid = 1'b1; axil_wvalid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (axil_awready && axil_wready) begin ok = 1; break; end
    end
    @(posedge clock); #1;
    axil_awvalid = 1'b0; axil_wvalid = 1'b0;
    if (!ok) timeout("axil_write");
  endtask

  task automatic rd_reg(input logic [31:0] a, output logic [31:0] d);
    bit ok = 0;
    d = 32'hxxxx_xxxx;
    axil_araddr = a; axil_arvalid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (axil_arready) begin ok = 1; break; end
    end
    @(posedge clock); #1;
    axil_arvalid = 1'b0;
    if (!ok) timeout("axil_read_addr");
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (axil_rvalid) begin d = axil_rdata; ok = 1; break; end
    end
    @(posedge clock); #1;
    if (!ok) timeout("axil_read_data");
  endtask

  task automatic wait_idle;
    bit ok = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clock);
      if (!const_out_valid && sb.size() == 0) begin ok = 1; break; end
    end
    @(posedge clock); #1;
    if (!ok) timeout("wait_idle");
  endtask

  initial begin
    logic [31:0] lo_tab [4];
    logic [31:0] hi_tab [4];
    logic [1:0]  pat_ready [6];
    lo_tab = '{32'h1000_0001, 32'h2000_0002, 32'h3000_0003, 32'h4000_0004};
    hi_tab = '{32'h11, 32'h22, 32'h33, 32'h44};
    pat_ready = '{2'd1, 2'd0, 2'd0, 2'd1, 2'd0, 2'd1};

    reset = 1'b1; sync = 1'b0; const_out_ready = 1'b1;
    axil_awaddr = 0; axil_awvalid = 0; axil_wdata = 0; axil_wstrb = 0; axil_wvalid = 0;
    axil_bready = 1'b1; axil_araddr = 0; axil_arvalid = 0; axil_rready = 1'b1;
    step(3);
    check("reset_outputs", 80'({const_out_valid, const_out_last, const_out_dest, const_out_data}), 80'd0);
    reset = 1'b0;
    step(1);
    rd_reg(32'h00, rd); check("reset_ctrl", 80'(rd), 80'h0);
    rd_reg(32'h04, rd); check("reset_status", 80'(rd), 80'h0);

    for (int i = 0; i < 4; i++) begin
      wr(32'(16 + 16 * i), lo_tab[i]);
      wr(32'(20 + 16 * i), hi_tab[i]);
      wr(32'(24 + 16 * i), 32'(i + 1));
    end
    wr(32'h00, 32'h0000_0301);

    // Three beats with ready held high.
    valid_cycles = 0;
    push3(D1);
    sync_pulse();
    check("first_beat_latency", 80'(const_out_valid), 80'd1);
    wait_idle();
    check("valid_cycles_3", 80'(valid_cycles), 80'd3);

    // Ready toggling 1,0,0,1,0,1.
    valid_cycles = 0;
    push3(D1);
    sync_pulse();
    for (int k = 0; k < 6; k++) begin
      const_out_ready = pat_ready[k][0];
      step(1);
    end
    const_out_ready = 1'b1;
    wait_idle();
    check("valid_cycles_stall", 80'(valid_cycles), 80'd6);

    // Back-to-back: restart the cycle after the final handshake.
    valid_cycles = 0;
    push3(D1);
    push3(D1);
    sync_pulse();
    step(3);
    check("b2b_gap", 80'(const_out_valid), 80'd0);
    sync_pulse();
    check("b2b_restart", 80'(const_out_valid), 80'd1);
    wait_idle();
    check("valid_cycles_b2b", 80'(valid_cycles), 80'd6);

    // Overrun: two syncs in RUN plus one on the final-handshake cycle.
    const_out_ready = 1'b0;
    push3(D1);
    sync_pulse();
    sync_pulse();
    sync_pulse();
    const_out_ready = 1'b1;
    step(2);
    sync = 1'b1;
    step(1);
    sync = 1'b0;
    check("overrun_no_restart", 80'(const_out_valid), 80'd0);
    rd_reg(32'h04, rd); check("overrun_count", 80'(rd), 80'h0003_0000);
    wr(32'h04, 32'h0);
    rd_reg(32'h04, rd); check("overrun_clear", 80'(rd), 80'h0);

    // One-shot.
    wr(32'h00, 32'h0000_0303);
    valid_cycles = 0;
    push3(D1);
    sync_pulse();
    wait_idle();
    rd_reg(32'h00, rd); check("one_shot_ctrl", 80'(rd), 80'h302);
    sync_pulse();
    step(5);
    check("one_shot_cycles", 80'(valid_cycles), 80'd3);

    // n_active = 0: sync and start both ignored.
    wr(32'h00, 32'h0000_0001);
    valid_cycles = 0;
    sync_pulse();
    wr(32'h00, 32'h0000_0005);
    step(5);
    check("n0_no_valid", 80'(valid_cycles), 80'd0);
    rd_reg(32'h04, rd); check("n0_status", 80'(rd), 80'h0);

    // n_active = 15 clamps to 4 beats.
    wr(32'h00, 32'h0000_0F01);
    valid_cycles = 0;
    push(D0, 8'd1, 1'b0); push(D1, 8'd2, 1'b0); push(D2, 8'd3, 1'b0); push(D3, 8'd4, 1'b1);
    sync_pulse();
    wait_idle();
    check("valid_cycles_clamp", 80'(valid_cycles), 80'd4);

    // Slot rewrite during a stalled sequence only affects the next one.
    wr(32'h00, 32'h0000_0301);
    const_out_ready = 1'b0;
    push3(D1);
    sync_pulse();
    wr(32'h20, 32'h0000_DEAD);
    const_out_ready = 1'b1;
    wait_idle();
    push3(D1N);
    sync_pulse();
    wait_idle();

    // Asynchronous reset mid-sequence.
    const_out_ready = 1'b0;
    sync_pulse();
    check("pre_reset_valid", 80'(const_out_valid), 80'd1);
    #2 reset = 1'b1;
    #1 check("reset_async_valid", 80'(const_out_valid), 80'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    const_out_ready = 1'b1;
    step(2);
    check("post_reset_valid", 80'(const_out_valid), 80'd0);
    rd_reg(32'h00, rd); check("post_reset_ctrl", 80'(rd), 80'h0);
    rd_reg(32'h04, rd); check("post_reset_status", 80'(rd), 80'h0);
    rd_reg(32'h20, rd); check("post_reset_slot1_low", 80'(rd), 80'h0);
    rd_reg(32'h14, rd); check("post_reset_slot0_high", 80'(rd), 80'h0);

    check("scoreboard_drain", 80'(sb.size()), 80'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
